// File: rtl/fake_n64_controller_rx.sv
// Joybus command receiver for a fake N64 controller.
// Decodes one command byte plus stop bit from the console line.
module fake_n64_controller_rx #(
    parameter int LEVEL_WIDTH = 2
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       cur_operation,
    input  logic       data_rx,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       tx_handoff,
    output logic       busy
);

    localparam int BIT_WIDTH = 4 * LEVEL_WIDTH;
    localparam int CW        = $clog2(BIT_WIDTH) + 1;

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_WIDTH);
    // A low phase shorter than two levels is a '1' (LHHH).
    localparam logic [CW-1:0] ONE_LIM  = CW'(2 * LEVEL_WIDTH);

    localparam logic [3:0] FRAME_BITS = 4'd9;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          tx_handoff_q, tx_handoff_d;

    logic          s_rx;
    logic          bit_val;
    logic          frame_ok;
    logic [CW-1:0] low_inc;
    logic [CW-1:0] high_inc;

    // Counters stick at all-ones instead of wrapping back to a short count.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + CNT_ONE;
    endfunction

    // The line is pulled up externally, so a floating line reads as 1 here.
    assign sync_d   = {sync_q[0], data_rx};
    assign s_rx     = sync_q[1];
    assign bit_val  = (low_cnt_q < ONE_LIM);
    assign low_inc  = sat_inc(low_cnt_q);
    assign high_inc = sat_inc(high_cnt_q);
    // Shift register holds 8 command bits followed by the stop bit in [0].
    assign frame_ok = (bit_cnt_q == FRAME_BITS) && shift_q[0];

    // Next-state and pulse logic; ARM reuses high_cnt as its idle counter.
    always_comb begin
        state_d      = state_q;
        low_cnt_d    = low_cnt_q;
        high_cnt_d   = high_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
        tx_handoff_d = tx_handoff_q;

        if (cur_operation) begin
            state_d    = ARM;
            low_cnt_d  = CNT_ZERO;
            high_cnt_d = CNT_ZERO;
            bit_cnt_d  = '0;
            shift_d    = '0;
        end else begin
            unique case (state_q)
                ARM: begin
                    if (!s_rx) begin
                        high_cnt_d = CNT_ZERO;
                    end else if (high_inc == CNT_MAX) begin
                        high_cnt_d = CNT_ZERO;
                        state_d    = IDLE;
                    end else begin
                        high_cnt_d = high_inc;
                    end
                end
                IDLE: begin
                    if (!s_rx) begin
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        low_cnt_d  = CNT_ONE;
                        high_cnt_d = CNT_ZERO;
                        state_d    = LOW;
                    end
                end
                LOW: begin
                    if (!s_rx) begin
                        if (low_inc == CNT_MAX) begin
                            frame_err_d = 1'b1;
                            low_cnt_d   = CNT_ZERO;
                            high_cnt_d  = CNT_ZERO;
                            state_d     = ARM;
                        end else begin
                            low_cnt_d = low_inc;
                        end
                    end else begin
                        shift_d    = {shift_q[7:0], bit_val};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        high_cnt_d = CNT_ONE;
                        state_d    = HIGH;
                    end
                end
                HIGH: begin
                    if (s_rx) begin
                        if (high_inc == CNT_MAX) begin
                            high_cnt_d = CNT_ZERO;
                            state_d    = IDLE;
                            if (frame_ok) begin
                                cmd_d        = shift_q[8:1];
                                cmd_valid_d  = 1'b1;
                                tx_handoff_d = ~tx_handoff_q;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                        end else begin
                            high_cnt_d = high_inc;
                        end
                    end else if (bit_cnt_q < FRAME_BITS) begin
                        low_cnt_d = CNT_ONE;
                        state_d   = LOW;
                    end else begin
                        frame_err_d = 1'b1;
                        low_cnt_d   = CNT_ZERO;
                        high_cnt_d  = CNT_ZERO;
                        state_d     = ARM;
                    end
                end
                default: begin
                    state_d = ARM;
                end
            endcase
        end
    end

    // State, counters and registered outputs; sync resets to idle-high.
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state_q      <= ARM;
            sync_q       <= 2'b11;
            low_cnt_q    <= CNT_ZERO;
            high_cnt_q   <= CNT_ZERO;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            cmd_q        <= 8'h00;
            cmd_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_handoff_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            low_cnt_q    <= low_cnt_d;
            high_cnt_q   <= high_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_err_q  <= frame_err_d;
            tx_handoff_q <= tx_handoff_d;
        end
    end

    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_err  = frame_err_q;
    assign tx_handoff = tx_handoff_q;
    assign busy       = (state_q == LOW) || (state_q == HIGH);

endmodule

// File: tb/tb_fake_n64_controller_rx.sv
// Directed bench for fake_n64_controller_rx, LEVEL_WIDTH=2.
// Frames are driven level by level; pulses are counted on negedge.
module tb_fake_n64_controller_rx;

    logic       sample_clk = 1'b0;
    logic       reset;
    logic       cur_operation;
    logic       data_rx;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       frame_err;
    logic       tx_handoff;
    logic       busy;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int nvalid    = 0;
    int nerr      = 0;
    int nboth     = 0;
    int valid_cyc = 0;
    int rise_cyc  = 0;
    int v0        = 0;
    int e0        = 0;

    fake_n64_controller_rx #(.LEVEL_WIDTH(2)) dut (
        .sample_clk   (sample_clk),
        .reset        (reset),
        .cur_operation(cur_operation),
        .data_rx      (data_rx),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .frame_err    (frame_err),
        .tx_handoff   (tx_handoff),
        .busy         (busy)
    );

    always #5 sample_clk = ~sample_clk;

    always @(posedge sample_clk) cyc <= cyc + 1;

    always @(negedge sample_clk) begin
        if (cmd_valid) begin
            nvalid++;
            valid_cyc = cyc;
        end
        if (frame_err) nerr++;
        if (cmd_valid && frame_err) nboth++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        data_rx = v;
        repeat (n) @(posedge sample_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b0, 2);
            hold(1'b1, 6);
        end else begin
            hold(1'b0, 6);
            hold(1'b1, 2);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int n,
                              input logic stop);
        for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
        if (stop) begin
            hold(1'b0, 2);
            rise_cyc = cyc;
            hold(1'b1, 6);
        end else begin
            send_bit(1'b0);
        end
        hold(1'b1, 12);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge sample_clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic mark();
        v0 = nvalid;
        e0 = nerr;
    endtask

    initial begin
        reset         = 1'b1;
        cur_operation = 1'b0;
        data_rx       = 1'b1;
        repeat (3) @(posedge sample_clk);
        #1;
        reset = 1'b0;

        check("rst_cmd", cmd, 8'h00);
        check("rst_valid", cmd_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_tx", tx_handoff, 0);
        check("rst_busy", busy, 0);
        hold(1'b1, 12);

        mark();
        send_frame(8'h01, 8, 1'b1);
        check("c01_cmd", cmd, 8'h01);
        check("c01_nvalid", nvalid - v0, 1);
        check("c01_nerr", nerr - e0, 0);
        check("c01_latency", valid_cyc - rise_cyc, 10);
        check("c01_tx", tx_handoff, 1);

        do_reset();
        hold(1'b1, 12);
        mark();
        send_frame(8'hFF, 8, 1'b1);
        check("cff_cmd", cmd, 8'hFF);
        check("cff_tx", tx_handoff, 1);
        send_frame(8'h00, 8, 1'b1);
        check("c00_cmd", cmd, 8'h00);
        check("c00_tx", tx_handoff, 0);
        check("cff00_nvalid", nvalid - v0, 2);
        check("cff00_nerr", nerr - e0, 0);

        mark();
        send_frame(8'h55, 7, 1'b1);
        check("short_nerr", nerr - e0, 1);
        check("short_nvalid", nvalid - v0, 0);
        check("short_cmd", cmd, 8'h00);
        check("short_tx", tx_handoff, 0);

        mark();
        send_frame(8'h02, 8, 1'b0);
        check("stop0_nerr", nerr - e0, 1);
        check("stop0_nvalid", nvalid - v0, 0);
        check("stop0_cmd", cmd, 8'h00);

        mark();
        hold(1'b0, 12);
        check("longlow_nerr", nerr - e0, 1);
        check("longlow_busy", busy, 0);
        hold(1'b1, 4);
        send_frame(8'h01, 8, 1'b1);
        check("arm_nvalid", nvalid - v0, 0);
        check("arm_nerr", nerr - e0, 1);
        mark();
        send_frame(8'hA5, 8, 1'b1);
        check("ca5_cmd", cmd, 8'hA5);
        check("ca5_tx", tx_handoff, 1);
        check("ca5_nvalid", nvalid - v0, 1);

        mark();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("abort_busy_pre", busy, 1);
        cur_operation = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        hold(1'b0, 2);
        hold(1'b1, 10);
        check("abort_busy", busy, 0);
        cur_operation = 1'b0;
        hold(1'b1, 12);
        check("abort_nvalid", nvalid - v0, 0);
        check("abort_nerr", nerr - e0, 0);
        check("abort_tx", tx_handoff, 1);
        check("abort_cmd", cmd, 8'hA5);
        mark();
        send_frame(8'h01, 8, 1'b1);
        check("post_abort_cmd", cmd, 8'h01);
        check("post_abort_tx", tx_handoff, 0);
        check("post_abort_nvalid", nvalid - v0, 1);

        send_frame(8'h3C, 8, 1'b1);
        check("c3c_cmd", cmd, 8'h3C);
        check("c3c_tx", tx_handoff, 1);
        mark();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        do_reset();
        check("midrst_cmd", cmd, 8'h00);
        check("midrst_tx", tx_handoff, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", cmd_valid, 0);
        check("midrst_err", frame_err, 0);
        hold(1'b1, 12);
        check("midrst_nvalid", nvalid - v0, 0);
        check("midrst_nerr", nerr - e0, 0);
        mark();
        send_frame(8'h00, 8, 1'b1);
        check("post_rst_nvalid", nvalid - v0, 1);
        check("post_rst_tx", tx_handoff, 1);
        check("post_rst_cmd", cmd, 8'h00);

        check("valid_err_overlap", nboth, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fake_n64_controller_rx.md
FAKE_N64_CONTROLLER_RX -- requirements
Module: fake_n64_controller_rx

Interface
REQ-001 The block SHALL have parameter LEVEL_WIDTH, default 2, meaning clk cycles per Joybus level; BIT_WIDTH = 4*LEVEL_WIDTH.
REQ-002 The block SHALL have port sample_clk, input, 1, the single clock; all logic on rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port cur_operation, input, 1: 0 = Rx owns line, 1 = Tx owns line (receiver ignores data_rx).
REQ-005 The block SHALL have port data_rx, input, 1, asynchronous Joybus line from console; idle high, z treated as 1.
REQ-006 The block SHALL have port cmd, output, 8, last valid command byte, MSB first on wire.
REQ-007 The block SHALL have port cmd_valid, output, 1, one-cycle pulse when cmd updates.
REQ-008 The block SHALL have port frame_err, output, 1, one-cycle pulse on malformed frame.
REQ-009 The block SHALL have port tx_handoff, output, 1, toggles once per valid command, handing the line to the transmitter.
REQ-010 The block SHALL have port busy, output, 1, high in states LOW and HIGH.

Function
REQ-011 The block SHALL pass data_rx through a 2-flop synchronizer; all decoding uses the synchronized value (s_rx); the 2-cycle delay is included in all latencies.
REQ-012 The block SHALL implement states ARM, IDLE, LOW, HIGH.
REQ-013 ARM: the block SHALL count consecutive s_rx=1 cycles; on reaching BIT_WIDTH, go to IDLE; any s_rx=0 restarts the count.
REQ-014 IDLE: on s_rx=0 the block SHALL clear bit count and shift register, set low_cnt=1, and go to LOW.
REQ-015 LOW: the block SHALL increment low_cnt each s_rx=0 cycle; if low_cnt reaches BIT_WIDTH, it SHALL pulse frame_err and go to ARM.
REQ-016 On s_rx=1 in LOW, the block SHALL decode the bit as 1 if low_cnt < 2*LEVEL_WIDTH, else 0, shift it in, increment bit count, set high_cnt=1, and go to HIGH.
REQ-017 HIGH: the block SHALL increment high_cnt each s_rx=1 cycle; on s_rx=0, if bit count < 9, set low_cnt=1 and go to LOW.
REQ-018 On s_rx=0 in HIGH with bit count = 9 (overflow), the block SHALL pulse frame_err and go to ARM.
REQ-019 When high_cnt reaches BIT_WIDTH in HIGH (end of frame), the block SHALL go to IDLE and evaluate the frame.
REQ-020 A frame SHALL be valid only if exactly 9 bits were received and the 9th (stop) bit decoded as 1.
REQ-021 On a valid frame, in the same cycle, the block SHALL load cmd with the first 8 bits (first received = bit 7), pulse cmd_valid, and toggle tx_handoff.
REQ-022 Otherwise the block SHALL pulse frame_err only; cmd and tx_handoff SHALL hold.
REQ-023 cmd_valid and frame_err SHALL never be high in the same cycle.
REQ-024 While cur_operation=1, the block SHALL be forced to ARM with counters cleared, and no pulses or toggles SHALL occur, including an abort mid-frame.
REQ-025 After cur_operation returns to 0, ARM SHALL guarantee BIT_WIDTH idle-high cycles before a new frame is accepted.
REQ-026 low_cnt and high_cnt SHALL be $clog2(BIT_WIDTH)+1 bits wide and saturate, never wrap.
REQ-027 Command bytes SHALL be passed through unfiltered; command interpretation belongs to the transmitter.

Reset
REQ-028 On reset, the block SHALL enter ARM and clear all counters and the shift register.
REQ-029 On reset, cmd=8'h00, cmd_valid=0, frame_err=0, tx_handoff=0, and busy=0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no pulse.

Verification (LEVEL_WIDTH=2; 0=LLLH, 1=LHHH, 2 cycles/level; stop=LHHH; line high >=8 cycles beforehand)
REQ-031 The bench SHALL drive 0x01 + stop -> cmd=8'h01, one cmd_valid pulse 8 cycles after the stop-bit rising edge (+2 sync), tx_handoff 0->1.
REQ-032 The bench SHALL drive 0xFF + stop, then 0x00 + stop -> cmd=8'hFF then 8'h00, two cmd_valid pulses, tx_handoff back to 0.
REQ-033 The bench SHALL drive 7 bits + stop (8 bits total) -> one frame_err, cmd and tx_handoff unchanged.
REQ-034 The bench SHALL drive 0x02 with stop encoded as 0 -> frame_err; hold line low 8 cycles -> frame_err, return to IDLE only after 8 high cycles.
REQ-035 The bench SHALL assert cur_operation=1 after bit 4 of a frame, then clear it -> no pulses, no toggle; the next full 0x01 frame decodes correctly.
REQ-036 The bench SHALL assert reset at bit 5 of a frame -> all outputs at reset values; the next full 0x00 frame decodes.
